// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and the
// single-layer shift function used by every pipeline stage.
package barrel_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // Shift/rotate a zero-extended operand of 'width' bits by k; bits above width come back zero.
  function automatic word_t shift_layer(input word_t data, input logic [1:0] mode,
                                        input int unsigned k, input int unsigned width);
    word_t mask;
    word_t msb_bit;
    word_t res;
    mask    = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    msb_bit = word_t'(1) << (width - 1);
    res     = '0;
    case (mode)
      MODE_ROR: res = (data >> k) | (data << (width - k));
      MODE_ROL: res = (data << k) | (data >> (width - k));
      MODE_SRL: res = data >> k;
      default: begin
        res = data >> k;
        if ((data & msb_bit) != '0) res = res | (~(mask >> k) & mask);
      end
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage of the barrel shifter: shifts by 2^STAGE when the
// matching amount bit is set, then registers the beat.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGE = 0,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  output logic             adv_o,
  input  logic             adv_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o,
  output logic [SHW-1:0]   amt_o,
  output logic [1:0]       mode_o
);

  localparam int unsigned K = 1 << STAGE;

  logic [WIDTH-1:0] d_next_c;

  always_comb begin
    d_next_c = d_i;
    if (amt_i[STAGE]) d_next_c = WIDTH'(shift_layer(MAX_W'(d_i), mode_i, K, WIDTH));
  end

  // An empty stage can always take a beat; a full one only when downstream moves.
  assign adv_o = !v_o | adv_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_o    <= 1'b0;
      d_o    <= '0;
      amt_o  <= '0;
      mode_o <= '0;
    end else if (adv_o) begin
      v_o <= v_i;
      if (v_i) begin
        d_o    <= d_next_c;
        amt_o  <= amt_i;
        mode_o <= mode_i;
      end
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (ROR/ROL/SRL/SRA) with one mux layer per stage and
// valid/ready handshakes on both sides; ready ripples back combinationally.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             v_s    [SHW+1];
  logic [WIDTH-1:0] d_s    [SHW+1];
  logic [SHW-1:0]   amt_s  [SHW+1];
  logic [1:0]       mode_s [SHW+1];
  logic             adv_s  [SHW+1];

  assign v_s[0]      = in_valid;
  assign d_s[0]      = in_data;
  assign amt_s[0]    = in_amt;
  assign mode_s[0]   = in_mode;
  assign adv_s[SHW]  = out_ready;
  assign in_ready    = adv_s[0];
  assign out_valid   = v_s[SHW];
  assign out_data    = d_s[SHW];

  // Amount and mode have no consumer past the last layer.
  logic unused_tail;
  assign unused_tail = ^{amt_s[SHW], mode_s[SHW]};

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (g),
      .SHW   (SHW)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .v_i    (v_s[g]),
      .d_i    (d_s[g]),
      .amt_i  (amt_s[g]),
      .mode_i (mode_s[g]),
      .adv_o  (adv_s[g]),
      .adv_i  (adv_s[g+1]),
      .v_o    (v_s[g+1]),
      .d_o    (d_s[g+1]),
      .amt_o  (amt_s[g+1]),
      .mode_o (mode_s[g+1])
    );
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and scoreboarded bench for barrel_shift_pipe (WIDTH=8 main, WIDTH=4 legacy).
module tb_barrel_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amt = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_data4 = '0;
  logic [1:0] in_amt4 = '0;
  logic [1:0] in_mode4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [3:0] out_data4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  barrel_shift_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_amt(in_amt4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
  );

  // Independent reference built from plain shifts on a doubled word.
  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] a,
                                      input logic [1:0] m);
    logic [15:0] t;
    case (m)
      2'b00: begin t = {d, d} >> a; return t[7:0]; end
      2'b01: begin t = {d, d} << a; return t[15:8]; end
      2'b10: return d >> a;
      default: return 8'($signed(d) >>> a);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL reset_out: got valid=%b data=%h, expected valid=0 data=00", out_valid, out_data);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1)
      $display("FAIL reset_ready: got in_ready=%b/%b, expected 1/1", in_ready, in_ready4);
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_ready4 !== 1'b1) fails++;
    else if (out_data !== 8'h00) fails++;
  endtask

  task automatic test_modes();
    logic [2:0] amts [4] = '{3'd2, 3'd3, 3'd3, 3'd3};
    logic [7:0] expv [4] = '{8'hA5, 8'hB4, 8'h12, 8'hF2};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h96; in_amt = amts[i]; in_mode = 2'(i); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mode%0d_early: got out_valid=%b, expected 0 two edges after handshake", i, out_valid);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== expv[i]) begin
        fails++;
        $display("FAIL mode%0d: got valid=%b data=%h, expected valid=1 data=%h", i, out_valid, out_data, expv[i]);
      end
    end
  endtask

  task automatic test_amt_zero();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h5C; in_amt = 3'd0; in_mode = 2'(i); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h5C) begin
        fails++;
        $display("FAIL amt0_mode%0d: got valid=%b data=%h, expected valid=1 data=5c", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_legacy_w4();
    logic [3:0] expv [4] = '{4'hD, 4'hE, 4'h7, 4'hB};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid4 = 1'b1; in_data4 = 4'hD; in_amt4 = 2'(i); in_mode4 = 2'b00; out_ready4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (out_valid4 !== 1'b1 || out_data4 !== expv[i]) begin
        fails++;
        $display("FAIL w4_ror_amt%0d: got valid=%b data=%h, expected valid=1 data=%h", i, out_valid4, out_data4, expv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bd   [4] = '{8'h81, 8'h3C, 8'hF0, 8'h07};
    logic [7:0] bexp [4] = '{8'hC0, 8'h1E, 8'hF8, 8'h03};
    int  got = 0;
    bit  acc3 = 1'b0;
    bit  hs_in;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = bd[i]; in_amt = 3'd1; in_mode = 2'b11;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_accept%0d: got in_ready=%b, expected 1", i, in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_data = bd[3];
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hC0) begin
      fails++;
      $display("FAIL bp_full: got in_ready=%b valid=%b data=%h, expected 0 1 c0", in_ready, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hC0) begin
      fails++;
      $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h, expected 0 1 c0", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 12 && got < 4; n++) begin
      #1;
      hs_in = in_valid && in_ready;
      if (hs_in && in_data == bd[3]) acc3 = 1'b1;
      if (out_valid) begin
        tests++;
        if (out_data !== bexp[got]) begin
          fails++;
          $display("FAIL bp_drain%0d: got %h, expected %h", got, out_data, bexp[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      if (hs_in) in_valid = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (got != 4 || !acc3) begin
      fails++;
      $display("FAIL bp_count: got %0d results accepted4=%b, expected 4 results accepted4=1", got, acc3);
    end
  endtask

  task automatic test_stream();
    logic [7:0] q [$];
    logic [7:0] e;
    int  sent = 0;
    int  rcvd = 0;
    int  cyc = 0;
    bit  in_hs, out_hs;
    @(negedge clk);
    in_valid = 1'b0;
    while (rcvd < 64 && cyc < 3000) begin
      if (!in_valid && sent < 64 && $urandom_range(0, 9) < 9) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_amt   = 3'($urandom);
        in_mode  = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (in_hs) begin
        q.push_back(ref8(in_data, in_amt, in_mode));
        sent++;
      end
      if (out_hs) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got unexpected beat %h, expected none", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e) begin
            fails++;
            $display("FAIL stream_beat%0d: got %h, expected %h", rcvd, out_data, e);
          end
        end
        rcvd++;
      end
      @(posedge clk); #1;
      if (in_hs) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (rcvd != 64 || sent != 64 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_count: got sent=%0d rcvd=%0d pending=%0d, expected 64 64 0", sent, rcvd, q.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1)); in_amt = 3'd1; in_mode = 2'b01;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_prefill: got out_valid=%b, expected 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_async: got valid=%b data=%h, expected 0 00", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: got in_ready=%b, expected 1", in_ready);
    end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++;
      $display("FAIL rst_stale: got %0d stale beats, expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_amt_zero();
    test_legacy_w4();
    test_backpressure();
    test_stream();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
